// File: rtl/fifo_drain_reader_pkg.sv
// fifo_drain_reader_pkg: shared widths, FSM encoding and channel indices for the egress drain reader.
package fifo_drain_reader_pkg;
  localparam int DATA_WIDTH = 10;
  localparam int COUNT_WIDTH = 5;
  typedef enum logic [1:0] {INIT, ACTIVE, DONE} state_e;
  localparam logic [1:0] CH4 = 2'd0;
  localparam logic [1:0] CH5 = 2'd1;
  localparam logic [1:0] CH6 = 2'd2;
  localparam logic [1:0] CH7 = 2'd3;
  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] c);
    return &c ? c : c + 1'b1;
  endfunction
endpackage

// File: rtl/fifo_drain_reader_if.sv
// fifo_drain_reader_if: FIFO egress, drained-word stream and count-query signals of the drain reader.
interface fifo_drain_reader_if;
  import fifo_drain_reader_pkg::*;
  logic init;
  logic IDLE;
  logic empty4, empty5, empty6, empty7;
  logic [DATA_WIDTH-1:0] FIFO_data_out4, FIFO_data_out5, FIFO_data_out6, FIFO_data_out7;
  logic pop4, pop5, pop6, pop7;
  logic [DATA_WIDTH-1:0] data_out;
  logic data_valid;
  logic [1:0] data_ch;
  logic req;
  logic [1:0] idx;
  logic [COUNT_WIDTH-1:0] cnt;
  logic cnt_valid;
  logic done;
  modport master (
    input init, IDLE, empty4, empty5, empty6, empty7,
    input FIFO_data_out4, FIFO_data_out5, FIFO_data_out6, FIFO_data_out7, req, idx,
    output pop4, pop5, pop6, pop7, data_out, data_valid, data_ch, cnt, cnt_valid, done
  );
  modport slave (
    output init, IDLE, empty4, empty5, empty6, empty7,
    output FIFO_data_out4, FIFO_data_out5, FIFO_data_out6, FIFO_data_out7, req, idx,
    input pop4, pop5, pop6, pop7, data_out, data_valid, data_ch, cnt, cnt_valid, done
  );
endinterface

// File: rtl/fifo_drain_reader_rr_pick4.sv
// rr_pick4: combinational round-robin picker, first requester at or after ptr wins.
module rr_pick4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  output logic [3:0] gnt_o,
  output logic [1:0] idx_o,
  output logic       any_o
);
  always_comb begin
    idx_o = ptr_i;
    for (int k = 3; k >= 0; k--) if (req_i[ptr_i + 2'(k)]) idx_o = ptr_i + 2'(k);
    any_o = |req_i;
    gnt_o = any_o ? 4'b0001 << idx_o : 4'b0000;
  end
endmodule

// File: rtl/fifo_drain_reader.sv
// fifo_drain_reader: round-robin drains FIFOs 4..7 into a tagged word stream with per-channel counts.
module fifo_drain_reader
  import fifo_drain_reader_pkg::*;
(
  input logic clk,
  input logic reset,
  fifo_drain_reader_if.master bus
);
  state_e state_q, state_d;
  logic [3:0] empty, gnt;
  logic [1:0] gnt_idx, ptr_q, ptr_d, p1_ch_q, ch_q;
  logic gnt_any, pop_en, pop_any, all_empty, in_flight, p1_v_q, dv_q, qv_q;
  logic [DATA_WIDTH-1:0] fifo_data [4];
  logic [DATA_WIDTH-1:0] dout_q;
  logic [COUNT_WIDTH-1:0] cnt_q [4];
  logic [COUNT_WIDTH-1:0] qcnt_q;

  assign empty = {bus.empty7, bus.empty6, bus.empty5, bus.empty4};
  assign all_empty = &empty;
  assign in_flight = p1_v_q | dv_q;

  always_comb begin
    fifo_data[CH4] = bus.FIFO_data_out4;
    fifo_data[CH5] = bus.FIFO_data_out5;
    fifo_data[CH6] = bus.FIFO_data_out6;
    fifo_data[CH7] = bus.FIFO_data_out7;
  end

  rr_pick4 picker (.req_i(~empty), .ptr_i(ptr_q), .gnt_o(gnt), .idx_o(gnt_idx), .any_o(gnt_any));

  always_ff @(posedge clk) state_q <= reset ? INIT : state_d;

  always_comb begin
    state_d = !bus.init ? INIT :
              state_q == INIT ? ACTIVE :
              (state_q == ACTIVE && all_empty && !in_flight && bus.IDLE) ? DONE :
              (state_q == DONE && !all_empty) ? ACTIVE : state_q;
  end

  // Dropping init stops pops in the same cycle, before the state register catches up.
  always_comb begin
    pop_en = state_q == ACTIVE && bus.init && !reset;
    bus.done = state_q == DONE;
  end

  assign pop_any = pop_en & gnt_any;
  assign ptr_d = pop_any ? gnt_idx + 2'd1 : ptr_q;
  assign {bus.pop7, bus.pop6, bus.pop5, bus.pop4} = pop_any ? gnt : 4'b0000;

  always_ff @(posedge clk)
    if (reset) begin
      ptr_q <= '0;
      p1_v_q <= 1'b0;
      p1_ch_q <= '0;
      dv_q <= 1'b0;
      ch_q <= '0;
      dout_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      p1_v_q <= pop_any;
      if (pop_any) p1_ch_q <= gnt_idx;
      dv_q <= p1_v_q;
      if (p1_v_q) begin
        dout_q <= fifo_data[p1_ch_q];
        ch_q <= p1_ch_q;
      end
    end

  always_ff @(posedge clk)
    if (reset) cnt_q <= '{default: '0};
    else if (dv_q) cnt_q[ch_q] <= sat_inc(cnt_q[ch_q]);

  always_ff @(posedge clk)
    if (reset) begin
      qv_q <= 1'b0;
      qcnt_q <= '0;
    end else begin
      qv_q <= bus.req;
      if (bus.req) qcnt_q <= cnt_q[bus.idx];
    end

  assign bus.data_out = dout_q;
  assign bus.data_valid = dv_q;
  assign bus.data_ch = ch_q;
  assign bus.cnt = qcnt_q;
  assign bus.cnt_valid = qv_q;
endmodule

// File: tb/tb_fifo_drain_reader.sv
// tb_fifo_drain_reader: directed pop-order tables plus a FIFO model and 2-cycle data scoreboard.
module tb_fifo_drain_reader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_drain_reader_if bus ();
  fifo_drain_reader dut (.clk(clk), .reset(reset), .bus(bus));

  typedef struct { logic init; logic [3:0] pop; } vec_t;
  typedef struct { logic [1:0] idx; int cnt; } qry_t;
  typedef struct { logic v; logic [1:0] ch; logic [9:0] w; } stg_t;

  vec_t tv[$];
  qry_t qv[$];
  logic [9:0] q[4][$];
  logic [9:0] fd[4];
  stg_t s1, s2;
  int checks = 0;
  int errors = 0;
  int words = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive();
    bus.empty4 = q[0].size() == 0;
    bus.empty5 = q[1].size() == 0;
    bus.empty6 = q[2].size() == 0;
    bus.empty7 = q[3].size() == 0;
    bus.FIFO_data_out4 = fd[0];
    bus.FIFO_data_out5 = fd[1];
    bus.FIFO_data_out6 = fd[2];
    bus.FIFO_data_out7 = fd[3];
  endtask

  // One clock: sample pops mid-cycle, then model the FIFOs and score the output stage.
  task automatic cyc(output logic [3:0] p);
    logic r;
    @(negedge clk);
    p = {bus.pop7, bus.pop6, bus.pop5, bus.pop4};
    r = reset;
    chk("pop_onehot", int'($onehot0(p)), 1);
    @(posedge clk);
    #1;
    s2 = s1;
    s1 = '{1'b0, 2'd0, 10'd0};
    for (int k = 0; k < 4; k++)
      if (p[k]) begin
        chk($sformatf("pop_nonempty%0d", k + 4), int'(q[k].size() > 0), 1);
        if (q[k].size() > 0) begin
          fd[k] = q[k].pop_front();
          s1 = '{1'b1, 2'(k), fd[k]};
        end
      end
    if (r) begin
      s1.v = 1'b0;
      s2.v = 1'b0;
    end
    drive();
    chk("data_valid", bus.data_valid, s2.v);
    if (s2.v && bus.data_valid) begin
      chk("data_ch", bus.data_ch, s2.ch);
      chk("data_out", bus.data_out, s2.w);
      words++;
    end
  endtask

  task automatic run(input int a, input int b);
    logic [3:0] p;
    for (int i = a; i < b; i++) begin
      bus.init = tv[i].init;
      cyc(p);
      chk($sformatf("pop_vec%0d", i), p, tv[i].pop);
    end
  endtask

  task automatic qry(input logic [1:0] idx, input int exp);
    logic [3:0] p;
    bus.req = 1'b1;
    bus.idx = idx;
    cyc(p);
    bus.req = 1'b0;
    chk($sformatf("cnt_valid%0d", idx), bus.cnt_valid, 1);
    chk($sformatf("cnt%0d", idx), bus.cnt, exp);
  endtask

  task automatic wait_done(input int bound);
    logic [3:0] p;
    for (int i = 0; i < bound && !bus.done; i++) cyc(p);
    chk("done", bus.done, 1);
  endtask

  task automatic add(input logic init, input logic [3:0] pop);
    tv.push_back('{init, pop});
  endtask

  initial begin
    logic [3:0] p;
    add(1, 4'h0); add(1, 4'h1); add(1, 4'h2); add(1, 4'h4); add(1, 4'h8);
    add(1, 4'h1); add(1, 4'h2); add(1, 4'h4); add(1, 4'h8);
    add(1, 4'h0); add(1, 4'h0); add(1, 4'h0);
    add(1, 4'h0); add(1, 4'h4); add(1, 4'h4); add(1, 4'h4); add(1, 4'h0); add(1, 4'h0); add(1, 4'h0);
    add(1, 4'h0); add(1, 4'h1); add(1, 4'h2); add(0, 4'h0); add(0, 4'h0); add(0, 4'h0); add(0, 4'h0);
    add(1, 4'h0); add(1, 4'h4); add(1, 4'h8); add(1, 4'h1); add(1, 4'h2); add(1, 4'h4); add(1, 4'h8);
    add(1, 4'h0); add(1, 4'h0); add(1, 4'h0);
    for (int k = 0; k < 4; k++) qv.push_back('{2'(k), 2});
    bus.init = 1'b1;
    bus.IDLE = 1'b1;
    bus.req = 1'b0;
    bus.idx = 2'd0;
    fd = '{default: '0};
    s1 = '{1'b0, 2'd0, 10'd0};
    s2 = s1;
    for (int k = 0; k < 4; k++) for (int j = 0; j < 2; j++) q[k].push_back(10'(k * 16 + j));
    drive();
    repeat (2) begin
      cyc(p);
      chk("rst_pop", p, 0);
      chk("rst_data_out", bus.data_out, 0);
      chk("rst_data_ch", bus.data_ch, 0);
      chk("rst_cnt", bus.cnt, 0);
      chk("rst_cnt_valid", bus.cnt_valid, 0);
      chk("rst_done", bus.done, 0);
    end
    reset = 1'b0;
    run(0, 12);
    wait_done(10);
    foreach (qv[i]) qry(qv[i].idx, qv[i].cnt);
    cyc(p);
    chk("cnt_valid_low", bus.cnt_valid, 0);
    chk("cnt_hold", bus.cnt, 2);

    reset = 1'b1;
    for (int j = 0; j < 3; j++) q[2].push_back(10'(12'h200 + j));
    drive();
    cyc(p);
    chk("rst_pop_t3", p, 0);
    reset = 1'b0;
    run(12, 19);
    qry(2, 3);
    qry(0, 0);

    for (int j = 0; j < 40; j++) q[1].push_back(10'(12'h100 + j));
    drive();
    words = 0;
    cyc(p);
    chk("done_drop", bus.done, 0);
    wait_done(60);
    chk("words_streamed", words, 40);
    qry(1, 31);

    reset = 1'b1;
    for (int k = 0; k < 4; k++) for (int j = 0; j < 2; j++) q[k].push_back(10'(12'h300 + k * 16 + j));
    drive();
    cyc(p);
    reset = 1'b0;
    run(19, 36);

    reset = 1'b1;
    for (int j = 0; j < 4; j++) q[3].push_back(10'(12'h3f0 + j));
    drive();
    cyc(p);
    reset = 1'b0;
    cyc(p);
    chk("t6_init_pop", p, 0);
    cyc(p);
    chk("t6_pop_a", p, 8);
    cyc(p);
    chk("t6_pop_b", p, 8);
    chk("t6_first_valid", bus.data_valid, 1);
    reset = 1'b1;
    cyc(p);
    chk("t6_rst_pop", p, 0);
    chk("t6_drop_valid", bus.data_valid, 0);
    chk("t6_fifo_left", q[3].size(), 2);
    reset = 1'b0;
    repeat (3) cyc(p);
    chk("t6_valid", bus.data_valid, 1);
    bus.req = 1'b1;
    bus.idx = 2'd3;
    cyc(p);
    chk("pre_inc_valid", bus.cnt_valid, 1);
    chk("pre_inc_cnt0", bus.cnt, 0);
    cyc(p);
    chk("pre_inc_cnt1", bus.cnt, 1);
    bus.req = 1'b0;
    cyc(p);
    chk("t6_cnt_valid_low", bus.cnt_valid, 0);
    qry(3, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
